mcu_rot_window: RTL and testbench

//  Parametrised memory control unit for the 2D convolution datapath, successor of the fixed 3x3 MCU.
//  - Manages M=N+K-1 column banks feeding N convolvers with KxK kernels.
//  - Sequences host load, convolution run and result unload.
//  - Rotates a base pointer so the K-1 overlap columns are reused between strips; only N banks are refilled.

---
 rtl/mcu_rot_window_pkg.sv | 29 ++
 rtl/mcu_rot_window_if.sv | 39 +++
 rtl/mcu_rot_window_bank_rotator.sv | 24 ++
 rtl/mcu_rot_window.sv | 154 +++++++++++++++
 tb/tb_mcu_rot_window.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_rot_window_pkg.sv
// Shared types and helpers for the rotating-window memory control unit.
// Physical bank index arithmetic is done with compare-and-subtract, never a divider.
package mcu_rot_window_pkg;

  typedef enum logic [1:0] {
    StLoad   = 2'b00,
    StRun    = 2'b01,
    StUnload = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // (a + b) mod m, valid while a, b < m
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
    int unsigned s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/mcu_rot_window_if.sv
// Host/datapath bus of the rotating-window memory control unit.
// Signal names keep the datapath's historical i_/o_ naming, seen from the MCU side.
interface mcu_rot_window_if #(
  parameter int unsigned N           = 2,
  parameter int unsigned K           = 3,
  parameter int unsigned BITS_IMAGEN = 8,
  parameter int unsigned BITS_DATA   = 13,
  parameter int unsigned BITS_ADDR   = 10
);
  localparam int unsigned M = N + K - 1;

  logic [BITS_IMAGEN-1:0]     i_Data;
  logic [N*BITS_DATA-1:0]     i_DataConv;
  logic [M*BITS_DATA-1:0]     i_MemData;
  logic [BITS_ADDR-1:0]       i_WAddr;
  logic [BITS_ADDR-1:0]       i_RAddr;
  logic                       i_chblk;
  logic                       i_sop;
  logic                       i_eop;
  logic [K*N*BITS_IMAGEN-1:0] o_DataConv;
  logic [BITS_DATA-1:0]       o_Data;
  logic [M-1:0]               o_we;
  logic [BITS_ADDR-1:0]       o_WAddr;
  logic [BITS_ADDR-1:0]       o_RAddr;
  logic [M*BITS_DATA-1:0]     o_MemData;
  logic [1:0]                 o_state;
  logic                       o_ready;

  modport slave (
    input  i_Data, i_DataConv, i_MemData, i_WAddr, i_RAddr, i_chblk, i_sop, i_eop,
    output o_DataConv, o_Data, o_we, o_WAddr, o_RAddr, o_MemData, o_state, o_ready
  );

  modport master (
    output i_Data, i_DataConv, i_MemData, i_WAddr, i_RAddr, i_chblk, i_sop, i_eop,
    input  o_DataConv, o_Data, o_we, o_WAddr, o_RAddr, o_MemData, o_state, o_ready
  );

endinterface

// File: rtl/mcu_rot_window_bank_rotator.sv
// Reorders physical bank lanes into logical order: logical lane L is physical lane
// (base + L) mod M.
module mcu_rot_window_bank_rotator
  import mcu_rot_window_pkg::*;
#(
  parameter int unsigned M    = 4,
  parameter int unsigned W    = 13,
  parameter int unsigned IdxW = 2
) (
  input  logic [IdxW-1:0] base_i,
  input  logic [M*W-1:0]  phys_i,
  output logic [M*W-1:0]  log_o
);

  always_comb begin
    log_o = '0;
    for (int unsigned l = 0; l < M; l++) begin
      for (int unsigned p = 0; p < M; p++) begin
        if (p == wrap_add(32'(base_i), l, M)) log_o[l*W +: W] = phys_i[p*W +: W];
      end
    end
  end

endmodule

// File: rtl/mcu_rot_window.sv
// Memory control unit for the NxK convolution datapath: loads banks from the host, feeds
// sliding windows to the convolvers, unloads results, and rotates the bank base per strip.
module mcu_rot_window
  import mcu_rot_window_pkg::*;
#(
  parameter int unsigned N           = 2,
  parameter int unsigned K           = 3,
  parameter int unsigned BITS_IMAGEN = 8,
  parameter int unsigned BITS_DATA   = 13,
  parameter int unsigned BITS_ADDR   = 10
) (
  input logic             clk,
  input logic             rst,
  mcu_rot_window_if.slave bus
);

  localparam int unsigned M    = N + K - 1;
  localparam int unsigned IdxW = clog2(M);
  localparam int unsigned PtrW = clog2(M + 1);

  state_e                     state_q;
  logic                       chblk_q;
  logic [IdxW-1:0]            base_q;
  logic [PtrW-1:0]            ptr_q;
  logic [PtrW-1:0]            need_q;
  logic                       ready_q;
  logic [M-1:0]               we_q;
  logic [M*BITS_DATA-1:0]     mem_data_q;
  logic [BITS_ADDR-1:0]       waddr_q;
  logic [K*N*BITS_IMAGEN-1:0] win_q;
  logic [BITS_DATA-1:0]       data_q;

  logic                       chblk_edge;
  logic [PtrW-1:0]            ptr_inc;
  int unsigned                load_phys;
  logic [IdxW-1:0]            next_base;
  logic [M-1:0]               load_we;
  logic [M-1:0]               run_we;
  logic [M*BITS_DATA-1:0]     load_wdata;
  logic [M*BITS_DATA-1:0]     run_wdata;
  logic [M*BITS_DATA-1:0]     log_lanes;
  logic [K*N*BITS_IMAGEN-1:0] win_d;
  logic [BITS_DATA-1:0]       unload_data;

  mcu_rot_window_bank_rotator #(
    .M    (M),
    .W    (BITS_DATA),
    .IdxW (IdxW)
  ) u_rotator (
    .base_i (base_q),
    .phys_i (bus.i_MemData),
    .log_o  (log_lanes)
  );

  assign load_wdata = {M{BITS_DATA'(bus.i_Data)}};
  assign next_base  = IdxW'(wrap_add(32'(base_q), N, M));

  always_comb begin
    chblk_edge  = bus.i_chblk & ~chblk_q;
    ptr_inc     = ptr_q + 1'b1;
    // Refill the oldest (M-need) .. M-1 logical banks in order
    load_phys   = wrap_add(32'(base_q), M - 32'(need_q) + 32'(ptr_q), M);
    load_we     = '0;
    run_we      = '0;
    run_wdata   = '0;
    win_d       = '0;
    unload_data = '0;
    for (int unsigned p = 0; p < M; p++) begin
      if (p == load_phys) load_we[p] = 1'b1;
    end
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned p = 0; p < M; p++) begin
        if (p == wrap_add(32'(base_q), j, M)) begin
          run_we[p]                        = 1'b1;
          run_wdata[p*BITS_DATA +: BITS_DATA] = bus.i_DataConv[j*BITS_DATA +: BITS_DATA];
        end
      end
      for (int unsigned t = 0; t < K; t++) begin
        win_d[(j*K+t)*BITS_IMAGEN +: BITS_IMAGEN] = log_lanes[(j+t)*BITS_DATA +: BITS_IMAGEN];
      end
    end
    for (int unsigned l = 0; l < M; l++) begin
      if (l == 32'(ptr_q)) unload_data = log_lanes[l*BITS_DATA +: BITS_DATA];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      chblk_q    <= 1'b0;
      base_q     <= '0;
      ptr_q      <= '0;
      need_q     <= PtrW'(M);
      ready_q    <= 1'b0;
      we_q       <= '0;
      mem_data_q <= '0;
      waddr_q    <= '0;
      win_q      <= '0;
      data_q     <= '0;
    end else begin
      chblk_q    <= bus.i_chblk;
      waddr_q    <= bus.i_WAddr;
      we_q       <= '0;
      mem_data_q <= '0;
      win_q      <= '0;
      data_q     <= '0;
      unique case (state_q)
        StLoad: begin
          mem_data_q <= load_wdata;
          if (chblk_edge && !ready_q) begin
            we_q  <= load_we;
            ptr_q <= ptr_inc;
            if (ptr_inc == need_q) ready_q <= 1'b1;
          end
          if (bus.i_sop && ready_q) begin
            state_q <= StRun;
            ptr_q   <= '0;
          end
        end
        StRun: begin
          we_q       <= run_we;
          mem_data_q <= run_wdata;
          win_q      <= win_d;
          if (bus.i_eop) state_q <= StUnload;
        end
        StUnload: begin
          data_q <= unload_data;
          if (chblk_edge) begin
            if (ptr_inc == PtrW'(N)) begin
              base_q  <= next_base;
              ptr_q   <= '0;
              need_q  <= PtrW'(N);
              ready_q <= 1'b0;
              state_q <= StLoad;
            end else begin
              ptr_q <= ptr_inc;
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign bus.o_RAddr    = (state_q != StLoad) ? bus.i_RAddr : '0;
  assign bus.o_we       = we_q;
  assign bus.o_MemData  = mem_data_q;
  assign bus.o_WAddr    = waddr_q;
  assign bus.o_DataConv = win_q;
  assign bus.o_Data     = data_q;
  assign bus.o_state    = state_q;
  assign bus.o_ready    = ready_q;

endmodule

// File: tb/tb_mcu_rot_window.sv
// Directed bench for mcu_rot_window (N=2, K=3): expected values are queued when stimulus is
// driven and compared against DUT outputs one cycle later.
module tb_mcu_rot_window;

  localparam int unsigned N  = 2;
  localparam int unsigned K  = 3;
  localparam int unsigned M  = N + K - 1;
  localparam int unsigned BI = 8;
  localparam int unsigned BD = 13;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mcu_rot_window_if bus ();

  mcu_rot_window dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty: got %0h required a queued expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s: got %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Window model for i_MemData lane p holding the value p
  function automatic logic [63:0] win_model(input int unsigned base);
    logic [63:0] w;
    w = '0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned t = 0; t < K; t++) begin
        w[(j*K+t)*BI +: BI] = 8'((base + j + t) % M);
      end
    end
    return w;
  endfunction

  function automatic logic [63:0] run_we_model(input int unsigned base);
    logic [63:0] w;
    w = '0;
    for (int unsigned j = 0; j < N; j++) w[(base + j) % M] = 1'b1;
    return w;
  endfunction

  // Drive one chblk pulse held two cycles, checking the write strobe and ready
  task automatic load_pulse(input string tag, input logic [63:0] exp_we, input logic exp_rdy);
    bus.i_chblk = 1'b1;
    push({tag, "_we"}, exp_we);
    push({tag, "_rdy"}, 64'(exp_rdy));
    step();
    chk(64'(bus.o_we));
    chk(64'(bus.o_ready));
    push({tag, "_we_hold"}, 64'h0);
    step();
    chk(64'(bus.o_we));
    bus.i_chblk = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] lanes_aa;
    int unsigned base;
    int unsigned need;

    bus.i_Data     = '0;
    bus.i_DataConv = '0;
    bus.i_MemData  = '0;
    bus.i_WAddr    = '0;
    bus.i_RAddr    = '0;
    bus.i_chblk    = 1'b0;
    bus.i_sop      = 1'b0;
    bus.i_eop      = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    push("rst_state", 64'h0);    chk(64'(bus.o_state));
    push("rst_ready", 64'h0);    chk(64'(bus.o_ready));
    push("rst_we", 64'h0);       chk(64'(bus.o_we));
    push("rst_conv", 64'h0);     chk(64'(bus.o_DataConv));
    push("rst_data", 64'h0);     chk(64'(bus.o_Data));

    // Initial load of all M banks, fifth pulse must be ignored
    bus.i_Data  = 8'hAA;
    bus.i_WAddr = 10'd1;
    lanes_aa    = 64'({4{13'h0AA}});
    base = 0;
    need = M;
    for (int unsigned k = 0; k < 5; k++) begin
      logic [63:0] we_exp;
      we_exp = (k < 4) ? 64'(1) << ((base + M - need + k) % M) : 64'h0;
      if (k == 0) begin
        bus.i_chblk = 1'b1;
        push("load_we0", we_exp);
        push("load_mdata", lanes_aa);
        push("load_waddr", 64'd1);
        step();
        chk(64'(bus.o_we));
        chk(64'(bus.o_MemData));
        chk(64'(bus.o_WAddr));
        step();
        bus.i_chblk = 1'b0;
        step();
      end else begin
        load_pulse($sformatf("load%0d", k), we_exp, k >= 3);
      end
    end

    // First RUN strip
    bus.i_MemData  = {13'h3, 13'h2, 13'h1, 13'h0};
    bus.i_DataConv = '1;
    bus.i_RAddr    = 10'h155;
    bus.i_sop      = 1'b1;
    push("sop_state", 64'h1);
    step();
    bus.i_sop = 1'b0;
    chk(64'(bus.o_state));
    push("run_raddr", 64'h155);  chk(64'(bus.o_RAddr));
    push("run0_win", win_model(0));
    push("run0_we", run_we_model(0));
    push("run0_mdata", 64'({13'h0, 13'h0, 13'h1FFF, 13'h1FFF}));
    step();
    chk(64'(bus.o_DataConv));
    chk(64'(bus.o_we));
    chk(64'(bus.o_MemData));

    // Unload two result banks
    bus.i_MemData = {13'h1444, 13'h1333, 13'h1222, 13'h1111};
    bus.i_eop     = 1'b1;
    push("eop_state", 64'h2);
    step();
    bus.i_eop = 1'b0;
    chk(64'(bus.o_state));
    push("unl_data0", 64'h1111);
    push("unl_we", 64'h0);
    step();
    chk(64'(bus.o_Data));
    chk(64'(bus.o_we));
    bus.i_chblk = 1'b1;
    step();
    push("unl_data1", 64'h1222);
    step();
    chk(64'(bus.o_Data));
    bus.i_chblk = 1'b0;
    step();
    bus.i_chblk = 1'b1;
    push("unl_back_state", 64'h0);
    push("unl_back_ready", 64'h0);
    step();
    chk(64'(bus.o_state));
    chk(64'(bus.o_ready));
    step();
    bus.i_chblk = 1'b0;
    step();

    // Refill only the N unloaded banks after base advance
    base = (base + N) % M;
    need = N;
    bus.i_Data = 8'h55;
    for (int unsigned k = 0; k < N; k++) begin
      load_pulse($sformatf("refill%0d", k), 64'(1) << ((base + M - need + k) % M), k == N - 1);
    end

    // Second RUN strip uses rotated lanes
    bus.i_MemData = {13'h3, 13'h2, 13'h1, 13'h0};
    bus.i_sop     = 1'b1;
    step();
    bus.i_sop = 1'b0;
    push("run1_win", win_model(base));
    push("run1_we", run_we_model(base));
    step();
    chk(64'(bus.o_DataConv));
    chk(64'(bus.o_we));

    // Simultaneous sop and eop in RUN: eop wins
    bus.i_sop = 1'b1;
    bus.i_eop = 1'b1;
    push("sop_eop_state", 64'h2);
    step();
    bus.i_sop = 1'b0;
    bus.i_eop = 1'b0;
    chk(64'(bus.o_state));

    // One unload pulse, then reset mid-UNLOAD
    bus.i_chblk = 1'b1;
    step();
    bus.i_chblk = 1'b0;
    step();
    rst = 1'b1;
    push("midrst_we", 64'h0);
    step();
    chk(64'(bus.o_we));
    rst = 1'b0;
    push("midrst_state", 64'h0);  chk(64'(bus.o_state));
    push("midrst_ready", 64'h0);  chk(64'(bus.o_ready));

    // sop with ready low is ignored
    bus.i_sop = 1'b1;
    push("sop_notready", 64'h0);
    step();
    bus.i_sop = 1'b0;
    chk(64'(bus.o_state));

    // Full M-bank load required again, from base 0
    base = 0;
    need = M;
    for (int unsigned k = 0; k < M; k++) begin
      load_pulse($sformatf("reload%0d", k), 64'(1) << ((base + M - need + k) % M), k == M - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
